sdram_pattern_tester: RTL and testbench
=======================================

Name: sdram_pattern_tester

Overview:
Self-test traffic generator that sits directly upstream of the SDRAM controller's user port, inside top.
- After the controller reports init done, it writes an address-derived pattern to NUM_WORDS consecutive words.
- It then reads every word back and compares it against the expected pattern.
- It latches a PASS or FAIL verdict, which top routes to LEDG[0] and LEDG[1].
- Single requester, one outstanding read at a time.

Parameters:
- ADDR_W, 24, word-address width (two ×16 devices form one 32-bit word; 16M words).
- DATA_W, 32, user data width; fixed at 32.
- BASE_ADDR, 0, first word address tested.
- NUM_WORDS, 1024, words tested; range 1..2^ADDR_W-BASE_ADDR.
- SEED, 32'hA5A5_0F0F, pattern XOR seed.
- TIMEOUT, 4096, maximum cycles allowed from read acceptance to rd_valid.

Ports:
- clk, in, 1, controller user clock (PLL c0 domain).
- rst_n, in, 1, asynchronous active-low reset.
- init_done, in, 1, controller init complete; level.
- req_valid, out, 1, request valid.
- req_ready, in, 1, controller accepts the request when req_valid and req_ready are both high.
- req_we, out, 1, 1 = write, 0 = read.
- req_addr, out, ADDR_W, word address.
- req_wdata, out, DATA_W, write data.
- rd_valid, in, 1, read data valid, one cycle per read.
- rd_data, in, DATA_W, read data.
- busy, out, 1, test in progress.
- pass, out, 1, sticky pass.
- fail, out, 1, sticky fail.
- err_code, out, 2, 0 = none, 1 = mismatch, 2 = timeout, 3 = spurious rd_valid.
- err_addr, out, ADDR_W, address of first failure.
- err_data, out, DATA_W, rd_data captured at the first mismatch; 0 otherwise.

Behaviour:
Reset
- Asynchronous reset forces state IDLE.
- All outputs 0; idx = 0; timer = 0.
- Assertion mid-transaction drops req_valid immediately. No recovery of in-flight controller state is attempted.

Pattern
- pat(a) = SEED ^ {~a[15:0], a[15:0]}, where a is the full word address.
- Address bits above 15 do not affect the pattern.

Addressing
- addr = BASE_ADDR + idx; idx counts 0..NUM_WORDS-1.
- Width is ADDR_W; there is no wrap check beyond the parameter range rule.

FSM states
- IDLE: busy = 0. When init_done = 1 → WRITE with idx = 0. The test runs once per reset.
- WRITE: req_valid = 1, req_we = 1, req_addr = addr, req_wdata = pat(addr).
  - On handshake: if idx == NUM_WORDS-1 → RD_REQ with idx = 0; else idx++.
  - req_valid stays high until accepted. Address and data must stay stable while req_valid is high and not yet accepted.
- RD_REQ: req_valid = 1, req_we = 0, req_wdata = 0. On handshake → RD_WAIT with timer = 0.
- RD_WAIT: req_valid = 0; timer increments every cycle.
  - rd_valid with rd_data == pat(addr): if last idx → PASS; else idx++ → RD_REQ.
  - rd_valid with a mismatch → FAIL with err_code = 1, err_addr = addr, err_data = rd_data.
  - timer == TIMEOUT-1 with no rd_valid → FAIL, err_code = 2.
  - rd_valid in the same cycle as the timeout: the data is evaluated and the timeout is ignored.
- PASS / FAIL: terminal until reset. pass or fail = 1, busy = 0, req_valid = 0.

Flags and timing
- busy = 1 in WRITE, RD_REQ and RD_WAIT.
- rd_valid seen in WRITE or RD_REQ → FAIL, err_code = 3, err_addr = addr. In IDLE, PASS and FAIL it is ignored.
- init_done deasserting after it was seen is ignored.
- Comparison is registered: the verdict and state change take effect the cycle after rd_valid.
- Minimum per-word read cost is 3 cycles + controller latency.
- pass and fail are never both 1.
- err_* fields are written only on the transition into FAIL.

Decomposition:
- Package sdram_tester_pkg contains:
  - state enum (IDLE, WRITE, RD_REQ, RD_WAIT, PASS, FAIL);
  - err_code localparams ERR_NONE, ERR_MISMATCH, ERR_TIMEOUT, ERR_SPURIOUS;
  - function pat(addr, seed).
- No sub-module: one FSM plus idx and timer counters.
- The existing system bench (two mt48lc16m16a2 instances, LEDG[0]/LEDG[1] monitor) is reused unchanged for integration.
- Block-level verification uses a stand-alone bench with a behavioural user-port responder.

Test Plan:
- Clean memory, NUM_WORDS = 16, req_ready always 1, CL = 2 responder: 16 writes then 16 reads; pass = 1 in ≤ 16 + 16×5 cycles; err_code = 0.
- Responder corrupts addr 5 data bit 0 (BASE_ADDR = 0): fail = 1, err_code = 1, err_addr = 5, err_data = pat(5) ^ 1; pass stays 0.
- Responder never returns read 3, TIMEOUT = 64: fail = 1, err_code = 2, err_addr = 3 exactly 64 cycles after read 3 is accepted.
- req_ready toggles pseudo-randomly: req_addr and req_wdata stay stable while stalled; each address is written exactly once; pass = 1.
- Injected rd_valid during WRITE: fail, err_code = 3. Separately, rd_valid coinciding with the timeout cycle and correct data: the read counts as good.
- rst_n pulsed low during RD_WAIT: all outputs 0 asynchronously; a fresh run after init_done ends in pass = 1.

Source files
------------

// File: rtl/sdram_tester_pkg.sv
// rtl/sdram_tester_pkg.sv - shared types and helpers for the SDRAM pattern tester
package sdram_tester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_REQ,
        RD_WAIT,
        PASS,
        FAIL
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_SPURIOUS = 2'd3;

    // Only the low 16 address bits feed the pattern; upper bits are ignored.
    function automatic logic [31:0] pat(input logic [15:0] addr_lo, input logic [31:0] seed);
        return seed ^ {~addr_lo, addr_lo};
    endfunction

endpackage

// File: rtl/sdram_pattern_tester.sv
// rtl/sdram_pattern_tester.sv - write/read-back self test on the SDRAM user port
module sdram_pattern_tester
    import sdram_tester_pkg::*;
#(
    parameter int          ADDR_W    = 24,
    parameter int          DATA_W    = 32,
    parameter int          BASE_ADDR = 0,
    parameter int          NUM_WORDS = 1024,
    parameter logic [31:0] SEED      = 32'hA5A5_0F0F,
    parameter int          TIMEOUT   = 4096
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              init_done_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_we_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [DATA_W-1:0] req_wdata_o,
    input  logic              rd_valid_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              busy_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic [1:0]        err_code_o,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic [DATA_W-1:0] err_data_o
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [TMR_W-1:0]    timer_q;
    logic                req_valid_q;
    logic                req_we_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic                busy_q;
    logic                pass_q;
    logic                fail_q;
    logic [1:0]          err_code_q;
    logic [ADDR_W-1:0]   err_addr_q;
    logic [DATA_W-1:0]   err_data_q;

    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                is_last;
    logic                rd_match;

    // req_addr_q always holds BASE + idx, so the next address is a plain increment.
    assign addr_d   = req_addr_q + 1'b1;
    assign wdata_d  = pat(addr_d[15:0], SEED);
    assign is_last  = (idx_q == LAST_IDX);
    assign rd_match = (rd_data_i == pat(req_addr_q[15:0], SEED));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            timer_q     <= '0;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_addr_q  <= '0;
            err_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (init_done_i) begin
                        state_q     <= WRITE;
                        idx_q       <= '0;
                        req_valid_q <= 1'b1;
                        req_we_q    <= 1'b1;
                        req_addr_q  <= BASE;
                        req_wdata_q <= pat(BASE[15:0], SEED);
                        busy_q      <= 1'b1;
                    end
                end
                WRITE: begin
                    if (rd_valid_i) begin
                        state_q     <= FAIL;
                        fail_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        req_valid_q <= 1'b0;
                        req_we_q    <= 1'b0;
                        err_code_q  <= ERR_SPURIOUS;
                        err_addr_q  <= req_addr_q;
                    end else if (req_ready_i) begin
                        if (is_last) begin
                            state_q     <= RD_REQ;
                            idx_q       <= '0;
                            req_we_q    <= 1'b0;
                            req_addr_q  <= BASE;
                            req_wdata_q <= '0;
                        end else begin
                            idx_q       <= idx_q + 1'b1;
                            req_addr_q  <= addr_d;
                            req_wdata_q <= wdata_d;
                        end
                    end
                end
                RD_REQ: begin
                    if (rd_valid_i) begin
                        state_q     <= FAIL;
                        fail_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        req_valid_q <= 1'b0;
                        err_code_q  <= ERR_SPURIOUS;
                        err_addr_q  <= req_addr_q;
                    end else if (req_ready_i) begin
                        state_q     <= RD_WAIT;
                        req_valid_q <= 1'b0;
                        timer_q     <= '0;
                    end
                end
                RD_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    // Data arriving on the timeout cycle wins over the timeout.
                    if (rd_valid_i) begin
                        if (!rd_match) begin
                            state_q    <= FAIL;
                            fail_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            err_code_q <= ERR_MISMATCH;
                            err_addr_q <= req_addr_q;
                            err_data_q <= rd_data_i;
                        end else if (is_last) begin
                            state_q <= PASS;
                            pass_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q     <= RD_REQ;
                            idx_q       <= idx_q + 1'b1;
                            req_addr_q  <= addr_d;
                            req_valid_q <= 1'b1;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        state_q    <= FAIL;
                        fail_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        err_code_q <= ERR_TIMEOUT;
                        err_addr_q <= req_addr_q;
                    end
                end
                default: begin
                    req_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req_valid_o = req_valid_q;
    assign req_we_o    = req_we_q;
    assign req_addr_o  = req_addr_q;
    assign req_wdata_o = req_wdata_q;
    assign busy_o      = busy_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign err_code_o  = err_code_q;
    assign err_addr_o  = err_addr_q;
    assign err_data_o  = err_data_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb/tb_sdram_pattern_tester.sv - stand-alone bench with behavioural user-port responder
module tb_sdram_pattern_tester;

    localparam int          NW   = 16;
    localparam int          TO   = 64;
    localparam logic [31:0] SEED = 32'hA5A5_0F0F;

    logic        clk;
    logic        rst_n;
    logic        init_done;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [1:0]  err_code;
    logic [23:0] err_addr;
    logic [31:0] err_data;

    sdram_pattern_tester #(
        .ADDR_W   (24),
        .DATA_W   (32),
        .BASE_ADDR(0),
        .NUM_WORDS(NW),
        .SEED     (SEED),
        .TIMEOUT  (TO)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .init_done_i(init_done),
        .req_valid_o(req_valid),
        .req_ready_i(req_ready),
        .req_we_o   (req_we),
        .req_addr_o (req_addr),
        .req_wdata_o(req_wdata),
        .rd_valid_i (rd_valid),
        .rd_data_i  (rd_data),
        .busy_o     (busy),
        .pass_o     (pass),
        .fail_o     (fail),
        .err_code_o (err_code),
        .err_addr_o (err_addr),
        .err_data_o (err_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pat(input int a);
        logic [15:0] lo;
        lo = a[15:0];
        return SEED ^ {16'hFFFF - lo, lo};
    endfunction

    // Responder memory and scenario knobs
    logic [31:0] mem [NW];
    int          wcount [NW];
    int          n_writes, rd_hs_count, last_rd_addr;
    int          ready_mode, rand_lat;
    int          corrupt_addr, corrupt_bit, drop_addr, slow_addr, slow_lat;
    int          drop_accept_cyc, inject_addr_exp;
    bit          inject_req;
    int          pend_delay = -1;
    logic [31:0] pend_data;
    bit          prev_stall = 1'b0;
    logic [23:0] prev_addr;
    logic [31:0] prev_wdata;
    logic        prev_we;

    initial begin
        req_ready = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        forever begin
            int a;
            int lat;
            @(negedge clk);
            if (prev_stall && rst_n) begin
                check("stall_valid", req_valid, 1);
                check("stall_addr", req_addr, prev_addr);
                check("stall_wdata", req_wdata, prev_wdata);
                check("stall_we", req_we, prev_we);
            end
            rd_valid = 1'b0;
            rd_data  = '0;
            if (!rst_n) begin
                pend_delay = -1;
                req_ready  = 1'b0;
                prev_stall = 1'b0;
                continue;
            end
            if (pend_delay > 0) begin
                pend_delay--;
                if (pend_delay == 0) begin
                    rd_valid   = 1'b1;
                    rd_data    = pend_data;
                    pend_delay = -1;
                end
            end
            if (inject_req) begin
                rd_valid        = 1'b1;
                rd_data         = 32'hDEAD_BEEF;
                inject_addr_exp = n_writes;
                inject_req      = 1'b0;
            end
            req_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (req_valid && req_ready) begin
                a = int'(req_addr);
                if (req_we) begin
                    if (a < NW) begin
                        mem[a] = req_wdata;
                        wcount[a]++;
                    end
                    n_writes++;
                end else begin
                    last_rd_addr = a;
                    rd_hs_count++;
                    if (a == drop_addr) begin
                        drop_accept_cyc = cyc;
                    end else begin
                        lat = (a == slow_addr) ? slow_lat :
                              (rand_lat != 0) ? int'($urandom_range(1, 6)) : 2;
                        pend_delay = lat;
                        pend_data  = (a < NW) ? mem[a] : 32'h0;
                        if (a == corrupt_addr) pend_data = pend_data ^ (32'd1 << corrupt_bit);
                    end
                end
            end
            prev_stall = req_valid && !req_ready;
            prev_addr  = req_addr;
            prev_wdata = req_wdata;
            prev_we    = req_we;
        end
    end

    task automatic clear_model();
        for (int i = 0; i < NW; i++) begin
            mem[i]    = '0;
            wcount[i] = 0;
        end
        n_writes        = 0;
        rd_hs_count     = 0;
        last_rd_addr    = -1;
        ready_mode      = 0;
        rand_lat        = 0;
        corrupt_addr    = -1;
        corrupt_bit     = 0;
        drop_addr       = -1;
        slow_addr       = -1;
        slow_lat        = 2;
        drop_accept_cyc = -1;
        inject_addr_exp = -1;
        inject_req      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        init_done = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int budget, output int used);
        used = 0;
        while (!(pass || fail) && used < budget) begin
            @(negedge clk);
            used++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_valid"}, req_valid, 0);
        check({tag, "_req_we"}, req_we, 0);
        check({tag, "_req_addr"}, req_addr, 0);
        check({tag, "_req_wdata"}, req_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_err_code"}, err_code, 0);
        check({tag, "_err_addr"}, err_addr, 0);
        check({tag, "_err_data"}, err_data, 0);
    endtask

    task automatic check_writes(input string tag);
        int bad;
        bad = 0;
        for (int a = 0; a < NW; a++) begin
            if (wcount[a] != 1 || mem[a] !== model_pat(a)) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        int used;
        int ca, cb;
        rst_n     = 1'b0;
        init_done = 1'b0;
        clear_model();

        // Reset state and idle hold without init_done
        do_reset();
        #1;
        check_all_zero("reset");
        repeat (5) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_req_valid", req_valid, 0);

        // Clean run, ready always high, latency 2
        init_done = 1'b1;
        wait_done(16 + 16 * 5, used);
        check("clean_pass", pass, 1);
        check("clean_fail", fail, 0);
        check("clean_err_code", err_code, 0);
        check("clean_busy", busy, 0);
        check("clean_reads", rd_hs_count, NW);
        check_writes("clean_writes");
        repeat (10) @(negedge clk);
        check("clean_pass_sticky", pass, 1);
        check("clean_req_valid_idle", req_valid, 0);

        // Corrupted bit 0 at address 5
        do_reset();
        corrupt_addr = 5;
        corrupt_bit  = 0;
        init_done    = 1'b1;
        wait_done(300, used);
        check("mis_fail", fail, 1);
        check("mis_pass", pass, 0);
        check("mis_err_code", err_code, 1);
        check("mis_err_addr", err_addr, 5);
        check("mis_err_data", err_data, model_pat(5) ^ 32'd1);

        // Random corruption under random stalls and latency
        do_reset();
        ca = int'($urandom_range(0, NW - 1));
        cb = int'($urandom_range(0, 31));
        corrupt_addr = ca;
        corrupt_bit  = cb;
        ready_mode   = 1;
        rand_lat     = 1;
        init_done    = 1'b1;
        wait_done(1500, used);
        check("rmis_fail", fail, 1);
        check("rmis_err_code", err_code, 1);
        check("rmis_err_addr", err_addr, ca);
        check("rmis_err_data", err_data, model_pat(ca) ^ (32'd1 << cb));

        // Random stalls, init_done dropped mid-run
        do_reset();
        ready_mode = 1;
        rand_lat   = 1;
        init_done  = 1'b1;
        repeat (6) @(negedge clk);
        init_done = 1'b0;
        wait_done(1500, used);
        check("rand_pass", pass, 1);
        check("rand_fail", fail, 0);
        check_writes("rand_writes");

        // Read 3 never answered
        do_reset();
        drop_addr = 3;
        init_done = 1'b1;
        wait_done(600, used);
        check("to_fail", fail, 1);
        check("to_err_code", err_code, 2);
        check("to_err_addr", err_addr, 3);
        check("to_err_data", err_data, 0);
        check("to_latency", cyc - drop_accept_cyc, TO + 1);

        // Spurious rd_valid while writing
        do_reset();
        init_done = 1'b1;
        used = 0;
        while (n_writes < 3 && used < 100) begin
            @(negedge clk);
            used++;
        end
        inject_req = 1'b1;
        wait_done(100, used);
        check("spur_fail", fail, 1);
        check("spur_pass", pass, 0);
        check("spur_err_code", err_code, 3);
        check("spur_err_addr", err_addr, inject_addr_exp);
        check("spur_err_data", err_data, 0);

        // rd_valid on the timeout cycle counts as a good read
        do_reset();
        slow_addr = 7;
        slow_lat  = TO;
        init_done = 1'b1;
        wait_done(600, used);
        check("edge_pass", pass, 1);
        check("edge_err_code", err_code, 0);

        // One cycle later the timeout wins
        do_reset();
        slow_addr = 7;
        slow_lat  = TO + 1;
        init_done = 1'b1;
        wait_done(600, used);
        check("late_fail", fail, 1);
        check("late_err_code", err_code, 2);
        check("late_err_addr", err_addr, 7);

        // Asynchronous reset pulse during RD_WAIT, then a fresh run
        do_reset();
        slow_addr = 2;
        slow_lat  = 40;
        init_done = 1'b1;
        used = 0;
        while (last_rd_addr != 2 && used < 200) begin
            @(negedge clk);
            used++;
        end
        repeat (5) @(negedge clk);
        check("pulse_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("pulse");
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done(300, used);
        check("pulse_rerun_pass", pass, 1);
        check("pulse_rerun_fail", fail, 0);
        check_writes("pulse_rerun_writes");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
